// File: rtl/uart_mem_sender_pkg.sv
// Shared constants and FSM state encoding for the memory-dump UART sender.
// The baud constant is the same one the io_module receiver uses.
package uart_mem_sender_pkg;

    localparam int unsigned DEF_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud
    localparam int unsigned DEF_ADDR_W       = 16;
    localparam int unsigned DEF_DATA_W       = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_WAIT,
        LOAD,
        TX_HI,
        TX_LO,
        NEXT,
        FIN
    } state_t;

endpackage

// File: rtl/uart_mem_sender_if.sv
// Control and BRAM read-port bundle of the memory-dump sender.
// master = host/memory side, slave = the sender itself.
interface uart_mem_sender_if
    import uart_mem_sender_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] word_count;
    logic [ADDR_W-1:0] addr_io;
    logic [DATA_W-1:0] data_in_io;
    logic              busy;
    logic              done;

    modport master (
        output start, base_addr, word_count, data_in_io,
        input  addr_io, busy, done
    );

    modport slave (
        input  start, base_addr, word_count, data_in_io,
        output addr_io, busy, done
    );

endinterface

// File: rtl/uart_mem_sender_tx_byte.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit.
// A load during the final stop-bit cycle chains the next frame with no idle gap.
module uart_tx_byte
    import uart_mem_sender_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk_100,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [8:0]       shift;
    logic             tx_int;

    assign frame_done = busy && (bit_idx == 4'd9) && (cnt == CNT_LAST);

    // tx is retimed one cycle behind tx_int so that launching from LOAD gives
    // a 4-cycle start latency and a 4-cycle idle gap between words.
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '1;
            busy    <= 1'b0;
            tx_int  <= 1'b1;
            tx      <= 1'b1;
        end else begin
            tx <= tx_int;
            if (load && (!busy || frame_done)) begin
                busy    <= 1'b1;
                cnt     <= '0;
                bit_idx <= '0;
                shift   <= {1'b1, data};
                tx_int  <= 1'b0;
            end else if (busy) begin
                if (cnt == CNT_LAST) begin
                    cnt <= '0;
                    if (bit_idx == 4'd9) begin
                        busy   <= 1'b0;
                        tx_int <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                        tx_int  <= shift[0];
                        shift   <= {1'b1, shift[8:1]};
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/uart_mem_sender.sv
// Dumps word_count BRAM words from base_addr over UART, upper byte first.
// Word FSM, address counter and remaining-word counter; serialiser is uart_tx_byte.
module uart_mem_sender
    import uart_mem_sender_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W
) (
    input  logic              clk_100,
    input  logic              rst,
    uart_mem_sender_if.slave  bus,
    output logic              tx,
    output logic              led_tx
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] remaining;
    logic [DATA_W-1:0] word_buf;
    logic              tx_load;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              tx_frame_done;

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            remaining <= '0;
            word_buf  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (bus.start) begin
                    addr_q    <= bus.base_addr;
                    remaining <= bus.word_count;
                end
                LOAD: word_buf <= bus.data_in_io;
                NEXT: begin
                    addr_q    <= addr_q + ADDR_W'(1);
                    remaining <= remaining - ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // The upper byte is launched straight from the BRAM data in LOAD; the
    // lower byte is chained from word_buf on the upper frame's last cycle.
    always_comb begin
        state_nx = state;
        tx_load  = 1'b0;
        tx_data  = word_buf[DATA_W-1 -: 8];
        case (state)
            IDLE:    if (bus.start) state_nx = (bus.word_count == '0) ? FIN : RD_ADDR;
            RD_ADDR: state_nx = RD_WAIT;
            RD_WAIT: state_nx = LOAD;
            LOAD: begin
                tx_load  = 1'b1;
                tx_data  = bus.data_in_io[DATA_W-1 -: 8];
                state_nx = TX_HI;
            end
            TX_HI: if (tx_frame_done) begin
                tx_load  = 1'b1;
                tx_data  = word_buf[7:0];
                state_nx = TX_LO;
            end
            TX_LO:   if (tx_frame_done || !tx_busy) state_nx = NEXT;
            NEXT:    state_nx = (remaining == ADDR_W'(1)) ? FIN : RD_ADDR;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_byte (
        .clk_100    (clk_100),
        .rst        (rst),
        .load       (tx_load),
        .data       (tx_data),
        .tx         (tx),
        .busy       (tx_busy),
        .frame_done (tx_frame_done)
    );

    assign bus.addr_io = addr_q;
    assign bus.busy    = (state != IDLE) && (state != FIN);
    assign bus.done    = (state == FIN);
    assign led_tx      = bus.busy;

endmodule

// File: tb/tb_uart_mem_sender.sv
// Self-checking bench for uart_mem_sender: BRAM model, UART frame decoder
// and a byte scoreboard filled when each dump is started.
module tb_uart_mem_sender;
    import uart_mem_sender_pkg::*;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic led_tx;

    int cyc      = 0;
    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    logic [15:0] mem [65536];

    typedef struct {
        logic [7:0] data;
        int         start;
        int         gap;
    } exp_t;
    exp_t exp_q [$];

    uart_mem_sender_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    uart_mem_sender #(.CLKS_PER_BIT(CPB), .ADDR_W(16), .DATA_W(16)) dut (
        .clk_100 (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .tx      (tx),
        .led_tx  (led_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.data_in_io <= mem[bus.addr_io];
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // UART decoder: every sample of a bit must match its first sample.
    bit         dec_on = 1'b0;
    int         dec_n, dec_start;
    int         last_end = 0;
    bit         uniform;
    logic       cur;
    logic [9:0] dec_bits;
    exp_t       e;

    always @(negedge clk) begin
        if (rst) begin
            dec_on = 1'b0;
        end else begin
            if (!dec_on && tx === 1'b0) begin
                dec_on    = 1'b1;
                dec_n     = 0;
                dec_start = cyc;
                uniform   = 1'b1;
            end
            if (dec_on) begin
                if (dec_n % CPB == 0) begin
                    cur                 = tx;
                    dec_bits[dec_n/CPB] = tx;
                end else if (tx !== cur) begin
                    uniform = 1'b0;
                end
                dec_n++;
                if (dec_n == FRAME) begin
                    dec_on = 1'b0;
                    if (exp_q.size() == 0) begin
                        check_eq("sb_underflow", 32'(dec_bits[8:1]), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("byte", 32'(dec_bits[8:1]), 32'(e.data));
                        check_eq("start_bit", 32'(dec_bits[0]), 32'd0);
                        check_eq("stop_bit", 32'(dec_bits[9]), 32'd1);
                        check_eq("bit_width", 32'(uniform), 32'd1);
                        if (e.start >= 0) check_eq("tx_latency", 32'(dec_start), 32'(e.start));
                        if (e.gap >= 0) check_eq("frame_gap", 32'(dec_start - last_end), 32'(e.gap));
                    end
                    last_end = cyc + 1;
                end
            end
        end
    end

    task automatic start_dump(input logic [15:0] base, input logic [15:0] count,
                              input bit push, output int k);
        exp_t        x;
        logic [15:0] a, w16;
        bus.base_addr  = base;
        bus.word_count = count;
        bus.start      = 1'b1;
        k = cyc + 1;
        if (push) begin
            for (int unsigned w = 0; w < 32'(count); w++) begin
                a       = base + 16'(w);
                w16     = mem[a];
                x.data  = w16[15:8];
                x.start = (w == 0) ? k + 4 : -1;
                x.gap   = (w == 0) ? -1 : 4;
                exp_q.push_back(x);
                x.data  = w16[7:0];
                x.start = -1;
                x.gap   = 0;
                exp_q.push_back(x);
            end
        end
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                dcyc = cyc;
                break;
            end
        end
        check_eq("done_seen", 32'(dcyc >= 0), 32'd1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    function automatic int done_at(input int k, input int n);
        return k + 4 + n * 2 * FRAME + (n - 1) * 4;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2, d, dc;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        for (int i = 0; i < 16; i++) begin
            mem[16'h0040 + 16'(i)] = 16'($urandom);
            mem[16'h0080 + 16'(i)] = 16'($urandom);
            mem[16'h0100 + 16'(i)] = 16'($urandom);
            mem[16'h0300 + 16'(i)] = 16'($urandom);
        end
        mem[16'h0010] = 16'h0FF0;
        mem[16'hFFFF] = 16'h1234;
        mem[16'h0000] = 16'hABCD;
        mem[16'h0020] = 16'h5AC3;
        mem[16'h0021] = 16'h96E1;

        repeat (3) @(negedge clk);
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_led", 32'(led_tx), 32'd0);
        check_eq("rst_addr", 32'(bus.addr_io), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single word, 0x0F then 0xF0
        start_dump(16'h0010, 16'd1, 1'b1, k);
        check_eq("t1_busy", 32'(bus.busy), 32'd1);
        check_eq("t1_led", 32'(led_tx), 32'd1);
        wait_done(3 * FRAME, d);
        check_eq("t1_done_cyc", 32'(d), 32'(done_at(k, 1)));
        check_eq("t1_busy_fin", 32'(bus.busy), 32'd0);
        check_eq("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // zero-length dump
        repeat (3) @(negedge clk);
        start_dump(16'h1234, 16'd0, 1'b1, k);
        wait_done(10, d);
        check_eq("t2_done_cyc", 32'(d), 32'(k));
        check_eq("t2_addr", 32'(bus.addr_io), 32'h1234);
        check_eq("t2_tx", 32'(tx), 32'd1);
        repeat (20) @(negedge clk);
        check_eq("t2_tx_idle", 32'(tx), 32'd1);

        // address wrap 0xFFFF -> 0x0000
        start_dump(16'hFFFF, 16'd2, 1'b1, k);
        wait_cyc(k + 4 + 2 * FRAME + 4 + FRAME / 2);
        check_eq("t3_addr_wrap", 32'(bus.addr_io), 32'h0000);
        wait_done(6 * FRAME, d);
        check_eq("t3_done_cyc", 32'(d), 32'(done_at(k, 2)));
        check_eq("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // start while busy is ignored
        repeat (2) @(negedge clk);
        start_dump(16'h0040, 16'd3, 1'b1, k);
        wait_cyc(k + 300);
        start_dump(16'h0080, 16'd5, 1'b0, k2);
        check_eq("t4_busy", 32'(bus.busy), 32'd1);
        wait_done(8 * FRAME, d);
        check_eq("t4_done_cyc", 32'(d), 32'(done_at(k, 3)));
        check_eq("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // reset in the middle of a data bit of the second byte
        repeat (2) @(negedge clk);
        start_dump(16'h0020, 16'd2, 1'b1, k);
        wait_cyc(k + 4 + FRAME + 3 * CPB + CPB / 2);
        dc  = done_cnt;
        rst = 1'b1;
        #1;
        check_eq("t5_rst_tx", 32'(tx), 32'd1);
        check_eq("t5_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("t5_rst_led", 32'(led_tx), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3 * FRAME) @(negedge clk);
        check_eq("t5_no_done", 32'(done_cnt), 32'(dc));
        check_eq("t5_tx_idle", 32'(tx), 32'd1);
        start_dump(16'h0020, 16'd2, 1'b1, k);
        wait_done(6 * FRAME, d);
        check_eq("t5_done_cyc", 32'(d), 32'(done_at(k, 2)));
        check_eq("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // back-to-back dumps; a start during the done cycle is ignored
        repeat (2) @(negedge clk);
        start_dump(16'h0100, 16'd3, 1'b1, k);
        wait_done(8 * FRAME, d);
        check_eq("t6a_done_cyc", 32'(d), 32'(done_at(k, 3)));
        start_dump(16'h0300, 16'd3, 1'b0, k2);
        start_dump(16'h0103, 16'd3, 1'b1, k);
        check_eq("t6_restart_k", 32'(k), 32'(d + 2));
        wait_done(8 * FRAME, d);
        check_eq("t6b_done_cyc", 32'(d), 32'(done_at(k, 3)));
        check_eq("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
